// File: rtl/bp_stall_snapshot_streamer.sv
// Captures all stall counters plus the cycle count into shadow registers on a host or timer
// trigger, then streams them as one framed valid/ready packet. States: IDLE = waiting for trigger,
// SEND = streaming shadow words.
module bp_stall_snapshot_streamer #(
  parameter int num_counters_p  = 24,
  parameter int counter_width_p = 32,
  parameter int drop_width_p    = 16
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic [num_counters_p*counter_width_p-1:0] counters_i,
  input  logic [31:0]                               cycle_i,
  input  logic                                      snap_req_i,
  input  logic [31:0]                               period_i,
  output logic [counter_width_p-1:0]                data_o,
  output logic                                      v_o,
  input  logic                                      ready_i,
  output logic                                      busy_o,
  output logic [7:0]                                seq_o,
  output logic [drop_width_p-1:0]                   dropped_o
);

  localparam int W     = counter_width_p;
  localparam int IDX_W = $clog2(num_counters_p + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_counters_p + 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t                  r_state, w_state_nx;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_pend;
  logic [7:0]              r_seq;
  logic [drop_width_p-1:0] r_dropped;
  logic [31:0]             r_timer;
  logic [31:0]             r_cycle;
  logic [W-1:0]            r_shadow [num_counters_p];

  logic         w_timer_fire;
  logic         w_trig;
  logic         w_accept;
  logic         w_last;
  logic         w_capture;
  logic [W-1:0] w_word;

  always_comb begin
    w_timer_fire = (period_i != 32'd0) && (r_timer >= period_i - 32'd1);
    w_trig       = snap_req_i | w_timer_fire;
    w_accept     = (r_state == ST_SEND) && ready_i;
    w_last       = w_accept && (r_idx == LAST_IDX);
  end

  always_comb begin
    w_state_nx = r_state;
    w_capture  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_capture  = 1'b1;
          w_state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        // A trigger landing on the final handshake is served immediately, like a pending one.
        if (w_last) begin
          if (r_pend || w_trig) w_capture = 1'b1;
          else                  w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_word = '0;
    if (r_idx == '0)                w_word = W'({8'hA5, r_seq, 16'(num_counters_p)});
    else if (r_idx == IDX_W'(1))    w_word = W'(r_cycle);
    else                            w_word = r_shadow[r_idx - IDX_W'(2)];
  end

  assign v_o       = (r_state == ST_SEND);
  assign busy_o    = (r_state == ST_SEND);
  assign data_o    = v_o ? w_word : '0;
  assign seq_o     = r_seq;
  assign dropped_o = r_dropped;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_pend    <= 1'b0;
      r_seq     <= '0;
      r_dropped <= '0;
      r_timer   <= '0;
      r_cycle   <= '0;
      for (int k = 0; k < num_counters_p; k++) r_shadow[k] <= '0;
    end else begin
      r_state <= w_state_nx;

      if (period_i == 32'd0 || w_timer_fire) r_timer <= '0;
      else                                   r_timer <= r_timer + 32'd1;

      if (w_capture) begin
        r_idx   <= '0;
        r_cycle <= cycle_i;
        for (int k = 0; k < num_counters_p; k++) r_shadow[k] <= counters_i[k*W +: W];
      end else if (w_accept) begin
        r_idx <= r_idx + IDX_W'(1);
      end

      if (w_last) r_seq <= r_seq + 8'd1;

      if (r_state == ST_SEND) begin
        // The re-capture consumes the pending slot; a concurrent trigger becomes the new pending one.
        if (w_last) begin
          r_pend <= r_pend & w_trig;
        end else if (w_trig) begin
          if (!r_pend)                r_pend    <= 1'b1;
          else if (r_dropped != '1)   r_dropped <= r_dropped + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_stall_snapshot_streamer.sv
// Directed self-checking bench for bp_stall_snapshot_streamer at default parameters.
module tb_bp_stall_snapshot_streamer;

  localparam int N = 24;

  logic            clk_i = 1'b0;
  logic            reset_n_i = 1'b1;
  logic [N*32-1:0] counters_i = '0;
  logic [31:0]     cycle_i = '0;
  logic            snap_req_i = 1'b0;
  logic [31:0]     period_i = '0;
  logic [31:0]     data_o;
  logic            v_o;
  logic            ready_i = 1'b0;
  logic            busy_o;
  logic [7:0]      seq_o;
  logic [15:0]     dropped_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] seq_exp;

  bp_stall_snapshot_streamer #(
    .num_counters_p(N), .counter_width_p(32), .drop_width_p(16)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .counters_i(counters_i), .cycle_i(cycle_i),
    .snap_req_i(snap_req_i), .period_i(period_i), .data_o(data_o), .v_o(v_o),
    .ready_i(ready_i), .busy_o(busy_o), .seq_o(seq_o), .dropped_o(dropped_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_counters(input logic [31:0] base);
    for (int k = 0; k < N; k++) counters_i[k*32 +: 32] = base + 32'(k);
  endtask

  function automatic logic [31:0] exp_word(input int w, input logic [7:0] s,
                                           input logic [31:0] base, input logic [31:0] cyc);
    if (w == 0)      return {8'hA5, s, 16'h0018};
    else if (w == 1) return cyc;
    else             return base + 32'(w - 2);
  endfunction

  task automatic apply_reset();
    snap_req_i = 1'b0; ready_i = 1'b0; period_i = '0;
    #1 reset_n_i = 1'b0;
    tick(); tick();
    reset_n_i = 1'b1;
    tick();
    seq_exp = 8'd0;
  endtask

  task automatic pulse_snap();
    snap_req_i = 1'b1;
    tick();
    snap_req_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (v_o !== 1'b0 || data_o !== 32'h0 || busy_o !== 1'b0 || seq_o !== 8'h0 || dropped_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: v=%b data=%h busy=%b seq=%h dropped=%h, required all zero",
               v_o, data_o, busy_o, seq_o, dropped_o);
    end
  endtask

  task automatic test_single();
    set_counters(32'h100);
    cycle_i = 32'h55;
    ready_i = 1'b1;
    pulse_snap();
    for (int w = 0; w < N + 2; w++) begin
      checks++;
      if (v_o !== 1'b1 || data_o !== exp_word(w, seq_exp, 32'h100, 32'h55)) begin
        errors++;
        $display("FAIL single_word%0d: v=%b data=%h, required v=1 data=%h",
                 w, v_o, data_o, exp_word(w, seq_exp, 32'h100, 32'h55));
      end
      tick();
    end
    seq_exp++;
    checks++;
    if (busy_o !== 1'b0 || seq_o !== seq_exp) begin
      errors++;
      $display("FAIL single_end: busy=%b seq=%h, required busy=0 seq=%h", busy_o, seq_o, seq_exp);
    end
  endtask

  task automatic test_backpressure();
    int w;
    int c;
    logic [3:0] pat;
    pat = 4'b1001;
    set_counters(32'h200);
    cycle_i = 32'h77;
    ready_i = 1'b0;
    pulse_snap();
    w = 0;
    c = 0;
    while (w < N + 2 && c < 200) begin
      checks++;
      if (v_o !== 1'b1 || data_o !== exp_word(w, seq_exp, 32'h200, 32'h77)) begin
        errors++;
        $display("FAIL bp_word%0d_cyc%0d: v=%b data=%h, required v=1 data=%h",
                 w, c, v_o, data_o, exp_word(w, seq_exp, 32'h200, 32'h77));
      end
      for (int k = 0; k < N; k++) counters_i[k*32 +: 32] = $urandom;
      cycle_i = $urandom;
      ready_i = pat[3 - (c % 4)];
      tick();
      if (ready_i) w++;
      c++;
    end
    ready_i = 1'b1;
    seq_exp++;
    checks++;
    if (w != N + 2 || busy_o !== 1'b0 || seq_o !== seq_exp) begin
      errors++;
      $display("FAIL bp_end: words=%0d busy=%b seq=%h, required words=26 busy=0 seq=%h",
               w, busy_o, seq_o, seq_exp);
    end
  endtask

  task automatic test_overlap();
    logic [31:0] base, cyc;
    logic [7:0]  s;
    set_counters(32'h300);
    cycle_i = 32'h1000;
    ready_i = 1'b1;
    pulse_snap();
    for (int w = 0; w < 2 * (N + 2); w++) begin
      if (w < N + 2) begin base = 32'h300; cyc = 32'h1000; s = seq_exp; end
      else           begin base = 32'h500; cyc = 32'h2000; s = seq_exp + 8'd1; end
      checks++;
      if (v_o !== 1'b1 || data_o !== exp_word(w % (N + 2), s, base, cyc)) begin
        errors++;
        $display("FAIL overlap_word%0d: v=%b data=%h, required v=1 data=%h",
                 w, v_o, data_o, exp_word(w % (N + 2), s, base, cyc));
      end
      snap_req_i = (w == 3 || w == 7);
      if (w == 20) begin
        set_counters(32'h500);
        cycle_i = 32'h2000;
      end
      tick();
    end
    snap_req_i = 1'b0;
    seq_exp = seq_exp + 8'd2;
    checks++;
    if (busy_o !== 1'b0 || dropped_o !== 16'd1 || seq_o !== seq_exp) begin
      errors++;
      $display("FAIL overlap_end: busy=%b dropped=%0d seq=%h, required busy=0 dropped=1 seq=%h",
               busy_o, dropped_o, seq_o, seq_exp);
    end
  endtask

  task automatic test_periodic();
    logic [7:0] s;
    apply_reset();
    set_counters(32'h400);
    cycle_i = 32'h9;
    ready_i = 1'b1;
    period_i = 32'd100;
    for (int k = 1; k <= 330; k++) begin
      tick();
      if (k == 99 || k == 199 || k == 299) begin
        checks++;
        if (v_o !== 1'b0) begin
          errors++;
          $display("FAIL periodic_early_k%0d: v=%b, required 0", k, v_o);
        end
      end
      if (k == 100 || k == 200 || k == 300) begin
        s = 8'(k / 100 - 1);
        checks++;
        if (v_o !== 1'b1 || data_o !== {8'hA5, s, 16'h0018}) begin
          errors++;
          $display("FAIL periodic_hdr_k%0d: v=%b data=%h, required v=1 data=%h",
                   k, v_o, data_o, {8'hA5, s, 16'h0018});
        end
      end
    end
    period_i = '0;
    tick();
    checks++;
    if (busy_o !== 1'b0 || seq_o !== 8'd3) begin
      errors++;
      $display("FAIL periodic_end: busy=%b seq=%h, required busy=0 seq=03", busy_o, seq_o);
    end
  endtask

  task automatic test_wrap_saturate();
    apply_reset();
    set_counters(32'h0);
    cycle_i = 32'h1;
    ready_i = 1'b1;
    for (int p = 0; p <= 256; p++) begin
      pulse_snap();
      if (p == 0 || p == 255 || p == 256) begin
        checks++;
        if (v_o !== 1'b1 || data_o !== {8'hA5, 8'(p), 16'h0018}) begin
          errors++;
          $display("FAIL wrap_hdr_p%0d: v=%b data=%h, required v=1 data=%h",
                   p, v_o, data_o, {8'hA5, 8'(p), 16'h0018});
        end
      end
      for (int w = 0; w < N + 2; w++) tick();
      if (p == 255) begin
        checks++;
        if (seq_o !== 8'h00) begin
          errors++;
          $display("FAIL wrap_seq: seq=%h, required 00", seq_o);
        end
      end
    end
    ready_i = 1'b0;
    snap_req_i = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    snap_req_i = 1'b0;
    checks++;
    if (dropped_o !== 16'hFFFF || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL drop_saturate: dropped=%h busy=%b, required FFFF busy=1", dropped_o, busy_o);
    end
    tick();
    checks++;
    if (dropped_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_hold: dropped=%h, required FFFF", dropped_o);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    set_counters(32'h700);
    cycle_i = 32'h3;
    ready_i = 1'b1;
    pulse_snap();
    for (int w = 0; w < 10; w++) tick();
    checks++;
    if (v_o !== 1'b1 || data_o !== 32'h708) begin
      errors++;
      $display("FAIL rst_mid_word10: v=%b data=%h, required v=1 data=00000708", v_o, data_o);
    end
    reset_n_i = 1'b0;
    #1;
    checks++;
    if (v_o !== 1'b0 || data_o !== 32'h0 || busy_o !== 1'b0 || seq_o !== 8'h0) begin
      errors++;
      $display("FAIL rst_mid_async: v=%b data=%h busy=%b seq=%h, required all zero",
               v_o, data_o, busy_o, seq_o);
    end
    tick();
    reset_n_i = 1'b1;
    tick();
    pulse_snap();
    checks++;
    if (v_o !== 1'b1 || data_o !== 32'hA5000018) begin
      errors++;
      $display("FAIL rst_mid_restart: v=%b data=%h, required v=1 data=a5000018", v_o, data_o);
    end
    for (int w = 0; w < N + 2; w++) tick();
  endtask

  initial begin
    seq_exp = 8'd0;
    test_reset();
    test_single();
    test_backpressure();
    test_overlap();
    test_periodic();
    test_wrap_saturate();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
